comparator_2bit_checker: RTL
============================

Name: comparator_2bit_checker

Overview:
- Self-checking response monitor for the 2-bit magnitude comparator; sits on the DUT output side, opposite the stimulus driver.
- Samples the operands applied to the comparator together with its three result flags, computes the golden result, and scores each vector.
- Accumulates pass/fail counts over a run of NUM_VECTORS samples and reports a final verdict plus the first failing vector.
- Used for on-chip BIST and for regression benches.

Parameters:
- NUM_VECTORS, 16: number of valid samples per run; legal range 1..(2**CNT_W)-1.
- CNT_W, 8: width of the vector, pass and fail counters.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a run; honoured only in IDLE or DONE.
- in_valid  input  1  qualifies the operand and flag inputs this cycle.
- x1  input  1  operand X MSB.
- x0  input  1  operand X LSB.
- y1  input  1  operand Y MSB.
- y0  input  1  operand Y LSB.
- x_greater_than_y  input  1  DUT flag.
- x_less_than_y  input  1  DUT flag.
- x_equal_to_y  input  1  DUT flag.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when fail_count == 0.
- err_pulse  output  1  one-cycle pulse per mismatching sample.
- vec_count  output  CNT_W  samples scored in the current run.
- pass_count  output  CNT_W  matching samples.
- fail_count  output  CNT_W  mismatching samples.
- first_fail  output  7  captured {x1,x0,y1,y0,gt,lt,eq} of the first failure.
- first_fail_valid  output  1  first_fail holds data.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) forces state IDLE and clears every output to 0: busy, done, pass, err_pulse, all counters, first_fail, first_fail_valid. Reset mid-run aborts the run with no verdict.
- Golden model: X={x1,x0}, Y={y1,y0}, unsigned. Expected {gt,lt,eq} = {X>Y, X<Y, X==Y}, always exactly one-hot.
- A sample mismatches if any of the three DUT flags differs from the expected value. Zero-hot and multi-hot flag patterns are therefore always failures.
- States and transitions:
  - IDLE -> RUN on start. Counters and capture are cleared in the same edge.
  - RUN: each cycle with in_valid=1 increments vec_count, plus exactly one of pass_count or fail_count.
  - RUN -> DONE on the edge that scores sample number NUM_VECTORS. That sample is scored normally.
  - DONE -> RUN on start, with a fresh clear. DONE holds all results until then.
- start in RUN is ignored; the run continues.
- in_valid in IDLE or DONE is ignored; no counter moves.
- start and in_valid in the same cycle in IDLE/DONE: the edge clears and enters RUN only. That sample is not scored.
- Latency: counters, err_pulse and first_fail update on the edge after the sampling cycle (1-cycle latency). done and pass assert on that same edge for the last vector.
- err_pulse is registered, high for exactly one cycle per failing sample; back-to-back failures give a continuous high.
- first_fail captures only when first_fail_valid=0; later failures do not overwrite it.
- pass is 0 outside DONE.
- Counters cannot overflow, given the legal NUM_VECTORS range.

Optional Feature:
- Macro: COMPARATOR_CHECKER_COVERAGE_EN.
- Defined: adds output ports cov_map (16 bits) and cov_full (1 bit).
  - Bit index {x1,x0,y1,y0} is set on any scored sample with that input pattern; cleared on reset and on run start.
  - cov_full = &cov_map, registered with the same 1-cycle latency.
  - In DONE, pass additionally requires cov_full=1.
- Undefined: no coverage ports or storage; pass depends on fail_count only.

Test Plan:
- Reset, start, then all 16 combinations (X=0..3, Y=0..3) with correct flags, 1 per cycle -> done=1 one cycle after the 16th sample, pass=1, pass_count=16, fail_count=0, err_pulse never high; with coverage: cov_map=16'hFFFF.
- Single injected fault: X=2,Y=1 with flags gt=0,lt=1,eq=0 among 15 correct samples -> fail_count=1, pass=0, err_pulse one cycle, first_fail=7'b1001010.
- Two faults (X=0,Y=0 flags 000; later X=3,Y=3 flags 111) -> first_fail=7'b0000000 retained, fail_count=2.
- Gapped in_valid plus start pulsed during RUN plus in_valid while IDLE -> only valid RUN samples counted, vec_count=16 at done, no restart.
- rst asserted after 7 samples -> next edge all outputs 0, IDLE; new start gives a clean 16-sample run with pass=1.
- Coverage build: 16 correct samples all X=1,Y=1 -> fail_count=0, cov_map=16'h0020, pass=0; without the macro, pass=1.

Source files
------------

// File: rtl/comparator_2bit_checker.sv
// rtl/comparator_2bit_checker.sv - scoring monitor for a 2-bit magnitude comparator (optional COMPARATOR_CHECKER_COVERAGE_EN)
module comparator_2bit_checker #(
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             x1,
    input  logic             x0,
    input  logic             y1,
    input  logic             y0,
    input  logic             x_greater_than_y,
    input  logic             x_less_than_y,
    input  logic             x_equal_to_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [6:0]       first_fail,
    output logic             first_fail_valid
`ifdef COMPARATOR_CHECKER_COVERAGE_EN
    ,
    output logic [15:0]      cov_map,
    output logic             cov_full
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             err_q, err_d;
    logic [6:0]       ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic [1:0]       x_val, y_val;
    logic [2:0]       exp_flags, dut_flags;
    logic             mismatch;

`ifdef COMPARATOR_CHECKER_COVERAGE_EN
    logic [15:0]      cov_q, cov_d;
    logic             covf_q;
`endif

    assign x_val     = {x1, x0};
    assign y_val     = {y1, y0};
    assign exp_flags = {x_val > y_val, x_val < y_val, x_val == y_val};
    assign dut_flags = {x_greater_than_y, x_less_than_y, x_equal_to_y};
    // Any deviation, including zero-hot or multi-hot flags, is a failure.
    assign mismatch  = (dut_flags != exp_flags);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pcnt_d  = pcnt_q;
        fcnt_d  = fcnt_q;
        err_d   = 1'b0;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
`ifdef COMPARATOR_CHECKER_COVERAGE_EN
        cov_d   = cov_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // A sample arriving with start is deliberately not scored.
                if (start) begin
                    state_d = S_RUN;
                    vec_d   = '0;
                    pcnt_d  = '0;
                    fcnt_d  = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
`ifdef COMPARATOR_CHECKER_COVERAGE_EN
                    cov_d   = '0;
`endif
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    vec_d = vec_q + CNT_W'(1);
                    if (mismatch) begin
                        fcnt_d = fcnt_q + CNT_W'(1);
                        err_d  = 1'b1;
                        if (!ffv_q) begin
                            ff_d  = {x_val, y_val, dut_flags};
                            ffv_d = 1'b1;
                        end
                    end else begin
                        pcnt_d = pcnt_q + CNT_W'(1);
                    end
`ifdef COMPARATOR_CHECKER_COVERAGE_EN
                    cov_d[{x_val, y_val}] = 1'b1;
`endif
                    if (vec_q == LAST_VEC) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            pcnt_q  <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pcnt_q  <= pcnt_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
        end
    end

`ifdef COMPARATOR_CHECKER_COVERAGE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cov_q  <= '0;
            covf_q <= 1'b0;
        end else begin
            cov_q  <= cov_d;
            covf_q <= &cov_d;
        end
    end

    assign cov_map  = cov_q;
    assign cov_full = covf_q;
    assign pass     = (state_q == S_DONE) && (fcnt_q == '0) && covf_q;
`else
    assign pass     = (state_q == S_DONE) && (fcnt_q == '0);
`endif

    assign busy             = (state_q == S_RUN);
    assign done             = (state_q == S_DONE);
    assign err_pulse        = err_q;
    assign vec_count        = vec_q;
    assign pass_count       = pcnt_q;
    assign fail_count       = fcnt_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule
